// File: rtl/uart_rx_fifo.sv
// Receive FIFO between uart_rx and the SoC IO read path.
// First-word-fall-through: head_data always shows the oldest byte, pop consumes it.
module uart_rx_fifo #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_dv,
  input  logic [7:0]        rx_byte,
  input  logic              pop,
  input  logic              clr_ovf,
  output logic [7:0]        head_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [31:0]       status
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              do_push, do_pop, drop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign do_pop  = pop & ~empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_push = rx_dv & (~full | pop);
  assign drop    = rx_dv & ~do_push;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= rx_byte;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  assign head_data = empty ? 8'h00 : mem[rd_ptr];
  assign status    = {29'b0, overflow, full, ~empty};
endmodule
